threshold_entry: RTL and testbench

Keypad parameter-entry controller for the water-detection design. Sits directly downstream of the matrix keypad scanner (`key_input`) and consumes its debounced key code. It turns key presses into a multi-digit BCD threshold: digits, confirm, backspace, clear and cancel. It holds the committed threshold for the comparator/alarm logic and exposes the in-progress entry for the display driver.

---
 rtl/threshold_entry.sv | 160 ++++++++++++++++
 tb/tb_threshold_entry.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/threshold_entry.sv
// Keypad parameter-entry controller: turns debounced key presses into a
// committed multi-digit BCD threshold, with edit, backspace, clear, cancel and idle timeout.
module threshold_entry #(
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [4*DIGITS-1:0] DEFAULT_BCD = (4*DIGITS)'(8'h50)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     key_code,
  input  logic                           key_valid,
  output logic [4*DIGITS-1:0]            threshold_bcd,
  output logic [4*DIGITS-1:0]            entry_bcd,
  output logic [$clog2(DIGITS+1)-1:0]    entry_len,
  output logic                           editing,
  output logic                           commit_pulse,
  output logic                           reject_pulse
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned LW = $clog2(DIGITS + 1);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [LW-1:0] MAX_LEN  = LW'(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] KEY_CONFIRM   = 4'hA;
  localparam logic [3:0] KEY_BACKSPACE = 4'hB;
  localparam logic [3:0] KEY_CLEAR     = 4'hC;
  localparam logic [3:0] KEY_CANCEL    = 4'hD;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic          prev_valid;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  entry_n, thr_n;
  logic [LW-1:0] len_n;
  logic          commit_n, reject_n;
  logic          press_c;
  logic          is_digit_c;

  assign press_c    = key_valid & ~prev_valid;
  assign is_digit_c = (key_code <= 4'd9);

  // State and registered outputs; prev_valid resets high so a key held through reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      prev_valid    <= 1'b1;
      cnt           <= '0;
      entry_bcd     <= '0;
      entry_len     <= '0;
      threshold_bcd <= DEFAULT_BCD;
      editing       <= 1'b0;
      commit_pulse  <= 1'b0;
      reject_pulse  <= 1'b0;
    end else begin
      state         <= state_n;
      prev_valid    <= key_valid;
      cnt           <= cnt_n;
      entry_bcd     <= entry_n;
      entry_len     <= len_n;
      threshold_bcd <= thr_n;
      editing       <= (state_n == EDIT);
      commit_pulse  <= commit_n;
      reject_pulse  <= reject_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    entry_n  = entry_bcd;
    len_n    = entry_len;
    thr_n    = threshold_bcd;
    commit_n = 1'b0;
    reject_n = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (press_c) begin
          if (is_digit_c) begin
            state_n = EDIT;
            entry_n = W'(key_code);
            len_n   = LW'(1);
          end else if (key_code != KEY_CLEAR && key_code != KEY_CANCEL) begin
            reject_n = 1'b1;
          end
        end
      end

      EDIT: begin
        if (press_c) begin
          // A press always wins over the timeout terminal count.
          cnt_n = '0;
          if (is_digit_c) begin
            if (entry_len < MAX_LEN) begin
              entry_n = W'({entry_bcd, key_code});
              len_n   = entry_len + LW'(1);
            end else begin
              reject_n = 1'b1;
            end
          end else begin
            case (key_code)
              KEY_CONFIRM: begin
                if (entry_len == '0) begin
                  reject_n = 1'b1;
                end else begin
                  thr_n    = entry_bcd;
                  commit_n = 1'b1;
                  entry_n  = '0;
                  len_n    = '0;
                  state_n  = IDLE;
                end
              end
              KEY_BACKSPACE: begin
                if (entry_len == '0) begin
                  reject_n = 1'b1;
                end else begin
                  entry_n = entry_bcd >> 4;
                  len_n   = entry_len - LW'(1);
                end
              end
              KEY_CLEAR: begin
                entry_n = '0;
                len_n   = '0;
              end
              KEY_CANCEL: begin
                entry_n = '0;
                len_n   = '0;
                state_n = IDLE;
              end
              default: reject_n = 1'b1;
            endcase
          end
        end else if (cnt == CNT_LAST) begin
          state_n  = IDLE;
          entry_n  = '0;
          len_n    = '0;
          cnt_n    = '0;
          reject_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_threshold_entry.sv
// Scoreboard bench for threshold_entry: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them, and checks pulses stay low otherwise.
module tb_threshold_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       key_valid;
  logic [7:0] threshold_bcd;
  logic [7:0] entry_bcd;
  logic [1:0] entry_len;
  logic       editing;
  logic       commit_pulse;
  logic       reject_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic       ed;
    logic [7:0] ent;
    logic [1:0] len;
    logic [7:0] thr;
    logic       cp;
    logic       rp;
  } exp_t;

  exp_t q[$];

  threshold_entry #(
    .DIGITS(2),
    .TIMEOUT_CYCLES(20),
    .DEFAULT_BCD(8'h50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_code(key_code),
    .key_valid(key_valid),
    .threshold_bcd(threshold_bcd),
    .entry_bcd(entry_bcd),
    .entry_len(entry_len),
    .editing(editing),
    .commit_pulse(commit_pulse),
    .reject_pulse(reject_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic expect_at(input int stamp, input logic ed, input logic [7:0] ent,
                           input logic [1:0] len, input logic [7:0] thr,
                           input logic cp, input logic rp);
    exp_t e;
    e.cyc = stamp; e.ed = ed; e.ent = ent; e.len = len;
    e.thr = thr;   e.cp = cp; e.rp = rp;
    q.push_back(e);
  endtask

  // Called at a negedge; the press is sampled on the next posedge (stamp).
  task automatic press(input logic [3:0] code, input int hold, input int gap,
                       input logic ed, input logic [7:0] ent, input logic [1:0] len,
                       input logic [7:0] thr, input logic cp, input logic rp,
                       output int stamp);
    key_code  = code;
    key_valid = 1'b1;
    stamp     = cyc + 1;
    expect_at(stamp, ed, ent, len, thr, cp, rp);
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pr(input logic [3:0] code, input logic ed, input logic [7:0] ent,
                    input logic [1:0] len, input logic [7:0] thr,
                    input logic cp, input logic rp);
    int st;
    press(code, 3, 2, ed, ent, len, thr, cp, rp, st);
  endtask

  // Monitor: compare a due expectation, otherwise pulses must be low.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("editing",       int'(editing),       int'(e.ed));
      chk("entry_bcd",     int'(entry_bcd),     int'(e.ent));
      chk("entry_len",     int'(entry_len),     int'(e.len));
      chk("threshold_bcd", int'(threshold_bcd), int'(e.thr));
      chk("commit_pulse",  int'(commit_pulse),  int'(e.cp));
      chk("reject_pulse",  int'(reject_pulse),  int'(e.rp));
    end else begin
      chk("commit_quiet", int'(commit_pulse), 0);
      chk("reject_quiet", int'(reject_pulse), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, s3;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    expect_at(1, 1'b0, 8'h00, 2'd0, 8'h50, 1'b0, 1'b0);
    expect_at(2, 1'b0, 8'h00, 2'd0, 8'h50, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-digit entry and commit
    pr(4'h3, 1, 8'h03, 2'd1, 8'h50, 0, 0);
    pr(4'h7, 1, 8'h37, 2'd2, 8'h50, 0, 0);
    pr(4'hA, 0, 8'h00, 2'd0, 8'h37, 1, 0);

    // Overflow digit, backspace, commit
    pr(4'h1, 1, 8'h01, 2'd1, 8'h37, 0, 0);
    pr(4'h2, 1, 8'h12, 2'd2, 8'h37, 0, 0);
    pr(4'h9, 1, 8'h12, 2'd2, 8'h37, 0, 1);
    pr(4'hB, 1, 8'h01, 2'd1, 8'h37, 0, 0);
    pr(4'hA, 0, 8'h00, 2'd0, 8'h01, 1, 0);

    // Idle timeout after 20 cycles without a press
    press(4'h4, 3, 2, 1, 8'h04, 2'd1, 8'h01, 0, 0, s);
    expect_at(s + 20, 0, 8'h00, 2'd0, 8'h01, 0, 1);
    while (cyc < s + 21) @(negedge clk);

    // Press on the terminal-count cycle wins over the timeout
    press(4'h4, 3, 2, 1, 8'h04, 2'd1, 8'h01, 0, 0, s2);
    while (cyc < s2 + 19) @(negedge clk);
    press(4'h3, 3, 2, 1, 8'h43, 2'd2, 8'h01, 0, 0, s3);
    expect_at(s3 + 20, 0, 8'h00, 2'd0, 8'h01, 0, 1);
    while (cyc < s3 + 21) @(negedge clk);

    // Cancel, confirm in IDLE, long hold
    pr(4'h5, 1, 8'h05, 2'd1, 8'h01, 0, 0);
    pr(4'hD, 0, 8'h00, 2'd0, 8'h01, 0, 0);
    pr(4'hA, 0, 8'h00, 2'd0, 8'h01, 0, 1);
    press(4'h8, 10, 2, 1, 8'h08, 2'd1, 8'h01, 0, 0, s);
    expect_at(cyc + 1, 1, 8'h08, 2'd1, 8'h01, 0, 0);
    @(negedge clk);
    pr(4'hD, 0, 8'h00, 2'd0, 8'h01, 0, 0);

    // Reset mid-edit with a key held through it
    pr(4'h6, 1, 8'h06, 2'd1, 8'h01, 0, 0);
    key_code = 4'h2; key_valid = 1'b1;
    expect_at(cyc + 1, 1, 8'h62, 2'd2, 8'h01, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    expect_at(cyc + 1, 0, 8'h00, 2'd0, 8'h50, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    expect_at(cyc + 1, 0, 8'h00, 2'd0, 8'h50, 0, 0);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    pr(4'h2, 1, 8'h02, 2'd1, 8'h50, 0, 0);

    // Unused key, clear, empty backspace/confirm
    pr(4'hE, 1, 8'h02, 2'd1, 8'h50, 0, 1);
    pr(4'hC, 1, 8'h00, 2'd0, 8'h50, 0, 0);
    pr(4'hB, 1, 8'h00, 2'd0, 8'h50, 0, 1);
    pr(4'hA, 1, 8'h00, 2'd0, 8'h50, 0, 1);

    // Leading-zero entry with back-to-back presses (one low cycle between)
    press(4'h0, 1, 1, 1, 8'h00, 2'd1, 8'h50, 0, 0, s);
    press(4'h5, 1, 1, 1, 8'h05, 2'd2, 8'h50, 0, 0, s);
    pr(4'hA, 0, 8'h00, 2'd0, 8'h05, 1, 0);

    // IDLE stays quiet well past the timeout period
    repeat (25) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
